// File: rtl/alarm_ctrl.sv
// ---------------------------------------------------------------------------
// alarm_ctrl: alarm-clock controller (set / ring / snooze), registered outputs.
// Optional SNOOZE state built when ALARM_SNOOZE_EN is defined.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alarm_ctrl #(
  parameter int RING_TICKS   = 600,
  parameter int SNOOZE_TICKS = 3000,
  parameter int BLINK_TICKS  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [23:0] time_bcd,
  input  logic        alarm_en,
  input  logic        btn_set,
  input  logic        btn_hr,
  input  logic        btn_min,
  input  logic        btn_snooze,
  input  logic        btn_off,
  output logic [15:0] alarm_bcd,
  output logic        ringing,
  output logic        buzz,
  output logic [31:0] disp_hexs
);

  localparam int RW = $clog2(RING_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam logic [RW-1:0] RING_LAST  = RW'(RING_TICKS - 1);
  localparam logic [RW-1:0] RING_FULL  = RW'(RING_TICKS);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SET = 2'd1, RING = 2'd2, SNOOZE = 2'd3} state_e;
  localparam int SW = $clog2(SNOOZE_TICKS + 1);
  localparam logic [SW-1:0] SNZ_LAST = SW'(SNOOZE_TICKS - 1);
  localparam logic [SW-1:0] SNZ_FULL = SW'(SNOOZE_TICKS);
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SET = 2'd1, RING = 2'd2} state_e;
  logic unused_snooze;
  assign unused_snooze = btn_snooze;
`endif

  state_e        state_q, state_d;
  logic [15:0]   alarm_q, alarm_d;
  logic          fired_q, fired_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          buzz_q, buzz_d;
  logic          ringing_q, ringing_d;
  logic [31:0]   disp_q, disp_d;
  logic          match;
  logic [7:0]    hr_inc, min_inc;

  assign match = alarm_en & (time_bcd[23:8] == alarm_q) & (time_bcd[7:0] == 8'h00) & ~fired_q;

  // BCD increments; minutes wrap without carrying into hours
  always_comb begin
    hr_inc = {alarm_q[15:12], alarm_q[11:8] + 4'd1};
    if (alarm_q[15:8] == 8'h23)      hr_inc = 8'h00;
    else if (alarm_q[11:8] == 4'd9)  hr_inc = {alarm_q[15:12] + 4'd1, 4'd0};
    min_inc = {alarm_q[7:4], alarm_q[3:0] + 4'd1};
    if (alarm_q[3:0] == 4'd9)
      min_inc = {(alarm_q[7:4] == 4'd5) ? 4'd0 : alarm_q[7:4] + 4'd1, 4'd0};
  end

  always_comb begin
    state_d     = state_q;
    alarm_d     = alarm_q;
    fired_d     = fired_q;
    ring_cnt_d  = ring_cnt_q;
    blink_cnt_d = blink_cnt_q;
    buzz_d      = buzz_q;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_d   = snz_cnt_q;
`endif
    if (time_bcd[7:0] != 8'h00) fired_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (btn_set) begin
          state_d = SET;
        end else if (match) begin
          state_d     = RING;
          fired_d     = 1'b1;
          ring_cnt_d  = '0;
          blink_cnt_d = '0;
          buzz_d      = 1'b1;
        end
      end
      SET: begin
        if (btn_hr)  alarm_d[15:8] = hr_inc;
        if (btn_min) alarm_d[7:0]  = min_inc;
        if (btn_set) state_d = IDLE;
      end
      RING: begin
        if (btn_off || !alarm_en) begin
          state_d = IDLE;
`ifdef ALARM_SNOOZE_EN
        end else if (btn_snooze) begin
          state_d   = SNOOZE;
          snz_cnt_d = '0;
`endif
        end else if (tick) begin
          if (ring_cnt_q >= RING_LAST) begin
            ring_cnt_d = RING_FULL;
            state_d    = IDLE;
          end else begin
            ring_cnt_d = ring_cnt_q + 1'b1;
          end
          if (blink_cnt_q >= BLINK_LAST) begin
            blink_cnt_d = '0;
            buzz_d      = ~buzz_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (btn_off || !alarm_en) begin
          state_d = IDLE;
        end else if (tick) begin
          if (snz_cnt_q >= SNZ_LAST) begin
            snz_cnt_d   = SNZ_FULL;
            state_d     = RING;
            ring_cnt_d  = '0;
            blink_cnt_d = '0;
            buzz_d      = 1'b1;
          end else begin
            snz_cnt_d = snz_cnt_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (state_d != RING) buzz_d = 1'b0;
    ringing_d = (state_d == RING);
    disp_d    = {2'b00, state_q, 3'b000, alarm_en,
                 (state_q == SET) ? {alarm_q, 8'h00} : time_bcd};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      alarm_q     <= 16'h0700;
      fired_q     <= 1'b0;
      ring_cnt_q  <= '0;
      blink_cnt_q <= '0;
      buzz_q      <= 1'b0;
      ringing_q   <= 1'b0;
      disp_q      <= 32'h0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      alarm_q     <= alarm_d;
      fired_q     <= fired_d;
      ring_cnt_q  <= ring_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      buzz_q      <= buzz_d;
      ringing_q   <= ringing_d;
      disp_q      <= disp_d;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q   <= snz_cnt_d;
`endif
    end
  end

  assign alarm_bcd = alarm_q;
  assign ringing   = ringing_q;
  assign buzz      = buzz_q;
  assign disp_hexs = disp_q;

endmodule

`default_nettype wire

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter RING_TICKS, default 600, tick count after which ringing auto-stops (60 s at 100 ms tick).
REQ-002 Parameter SNOOZE_TICKS, default 3000, tick count of snooze interval (5 min).
REQ-003 Parameter BLINK_TICKS, default 5, tick count per buzz half-period.
REQ-004 clk  input  1  system clock; all logic in this single domain.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 tick  input  1  one-clk strobe per 100 ms time-base step, synchronous to clk.
REQ-007 time_bcd  input  24  current time {H1,H0,M1,M0,S1,S0}, BCD.
REQ-008 alarm_en  input  1  arm switch level; 1 = armed.
REQ-009 btn_set, btn_hr, btn_min, btn_snooze, btn_off  input  1 each  debounced one-clk pulses.
REQ-010 alarm_bcd  output  16  alarm time {H1,H0,M1,M0}, BCD.
REQ-011 ringing  output  1  high while in RING.
REQ-012 buzz  output  1  blink/buzzer pattern, low outside RING.
REQ-013 disp_hexs  output  32  digit word for downstream display drivers.

Function
REQ-014 FSM states IDLE, SET, RING, SNOOZE (codes 0..3); all outputs registered.
REQ-015 match = alarm_en & (time_bcd[23:8]==alarm_bcd) & (time_bcd[7:0]==8'h00) & ~fired.
REQ-016 fired set when IDLE->RING is taken; cleared whenever time_bcd[7:0]!=8'h00; one trigger per matching minute.
REQ-017 IDLE: btn_set -> SET; else match -> RING; btn_set wins if both same cycle.
REQ-018 SET: btn_hr increments hours 00..23, 23->00; btn_min increments minutes 00..59, 59->00, no carry into hours; btn_set -> IDLE; match suppressed.
REQ-019 SET: btn_hr and btn_min same cycle -> both fields increment.
REQ-020 RING: counter clears on entry, increments per tick; reaching RING_TICKS -> IDLE.
REQ-021 RING exit priority: btn_off or alarm_en=0 -> IDLE; else btn_snooze -> SNOOZE; btn_set ignored.
REQ-022 buzz: 1 on RING entry, toggles every BLINK_TICKS ticks; forced 0 on leaving RING.
REQ-023 SNOOZE: counter clears on entry, increments per tick; reaching SNOOZE_TICKS -> RING with ring counter cleared.
REQ-024 SNOOZE: btn_off or alarm_en=0 -> IDLE, priority over timeout in same cycle.
REQ-025 disp_hexs[23:0] = SET ? {alarm_bcd,8'h00} : time_bcd; [27:24] = {3'b0,alarm_en}; [31:28] = state code; latency 1 clk.
REQ-026 Counters saturate-safe: no wrap past terminal count; width ceil(log2(param+1)).

Reset
REQ-027 rst low asynchronously forces: state IDLE, alarm_bcd 16'h0700, fired 0, counters 0, ringing 0, buzz 0, disp_hexs 32'h0.
REQ-028 Reset mid-RING or mid-SET discards progress; first post-reset clk edge resumes normal operation from IDLE.

Configuration
REQ-029 Macro ALARM_SNOOZE_EN defined: SNOOZE state and counter present per REQ-021/023/024.
REQ-030 Macro ALARM_SNOOZE_EN undefined: no SNOOZE state or counter; btn_snooze ignored; RING exits only via btn_off, disarm, or timeout.

Verification (RING_TICKS=20, SNOOZE_TICKS=30, BLINK_TICKS=2)
REQ-031 Reset then release -> alarm_bcd=0700, ringing=0, disp_hexs[31:28]=0.
REQ-032 SET, btn_hr x17, btn_min x60, btn_set -> alarm_bcd=0000 (hours 07->23->00, minutes wrap to 00); disp_hexs[23:0]=000000 while in SET.
REQ-033 alarm 0700, alarm_en=1, time_bcd 065959->070000 -> ringing=1 next clk; buzz 1,1,0,0,1 over ticks; 20 ticks -> IDLE; time held at 070000 -> no retrigger.
REQ-034 RING, btn_snooze -> SNOOZE (code 3), ringing=0; 30 ticks -> RING; btn_off + btn_snooze same cycle -> IDLE.
REQ-035 RING, alarm_en dropped -> IDLE next clk, buzz=0; rst pulsed mid-RING -> immediate IDLE, alarm_bcd=0700.
REQ-036 Build without ALARM_SNOOZE_EN, RING, btn_snooze -> stays RING; timeout at 20 ticks -> IDLE.
